// File: rtl/mop_queue.sv
// Micro-op buffer between the x86 decoder and register read: ENQ_W in, DEQ_W out, in order.
// Optional same-cycle enq->deq bypass when empty: define MOP_QUEUE_BYPASS_EN.
package mop_pkg;

  typedef enum logic [4:0] {
    M_NOP,
    M_ADD,
    M_SUB,
    M_LD,
    M_ST,
    M_MUL,
    M_JMIN,
    M_JMP,
    M_JZ,
    M_JNZ,
    M_CALL,
    M_RET,
    M_JMAX,
    M_FENCE
  } mop_op_e;

  typedef struct packed {
    mop_op_e     opcode;
    logic [3:0]  dst;
    logic [3:0]  src1;
    logic [3:0]  src2;
    logic [15:0] disp;
  } micro_op_t;

  function automatic logic is_br(micro_op_t m);
    return (m.opcode > M_JMIN) && (m.opcode < M_JMAX);
  endfunction

endpackage

module mop_queue
  import mop_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int ENQ_W = 3,
  parameter int DEQ_W = 2,
  localparam int MW = $bits(micro_op_t),
  localparam int EW = $clog2(ENQ_W + 1),
  localparam int DW = $clog2(DEQ_W + 1),
  localparam int OW = $clog2(DEPTH + 1),
  localparam int PW = $clog2(DEPTH),
  localparam int LW = (ENQ_W > DEQ_W) ? ENQ_W : DEQ_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic [EW-1:0]       enq_count,
  input  logic [ENQ_W*MW-1:0] enq_mops,
  output logic                enq_ready,
  output logic [DW-1:0]       deq_count,
  output logic [DEQ_W*MW-1:0] deq_mops,
  input  logic [DW-1:0]       deq_take,
  output logic [OW-1:0]       occupancy,
  output logic [OW-1:0]       br_count
);

  micro_op_t        mem_q [DEPTH];
  micro_op_t        mem_d [DEPTH];
  logic [DEPTH-1:0] mem_we;
  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [OW-1:0]    occ_q, occ_d;
  logic [OW-1:0]    br_q, br_d;
  logic             byp;
  micro_op_t        lane [LW];
  micro_op_t        ent;
  micro_op_t        rd;
  int               enq_n, avail, take, base, wr_n;
  int               br_in, br_out;

  always_comb begin
    for (int i = 0; i < LW; i++) begin
      lane[i] = '0;
      if (i < ENQ_W) lane[i] = enq_mops[i*MW +: MW];
    end
  end

  assign enq_ready = (OW'(DEPTH) - occ_q) >= OW'(ENQ_W);
  assign occupancy = occ_q;
  assign br_count  = br_q;

  always_comb begin
    enq_n = (int'(enq_count) > ENQ_W) ? ENQ_W : int'(enq_count);
    byp   = 1'b0;
`ifdef MOP_QUEUE_BYPASS_EN
    byp   = (occ_q == '0) && !flush;
`endif
    if (byp)
      avail = enq_ready ? ((enq_n < DEQ_W) ? enq_n : DEQ_W) : 0;
    else
      avail = (int'(occ_q) < DEQ_W) ? int'(occ_q) : DEQ_W;
    take  = (int'(deq_take) < avail) ? int'(deq_take) : avail;
    // bypassed lanes are consumed straight off the enq bus, never stored
    base  = byp ? take : 0;
    wr_n  = (enq_ready && !flush) ? enq_n - base : 0;

    deq_count = DW'(avail);
    deq_mops  = '0;
    ent       = '0;
    for (int j = 0; j < DEQ_W; j++) begin
      if (j < avail) begin
        ent = byp ? lane[j] : mem_q[PW'(int'(head_q) + j)];
        deq_mops[j*MW +: MW] = ent;
      end
    end

    mem_we = '0;
    br_in  = 0;
    for (int k = 0; k < DEPTH; k++) mem_d[k] = '0;
    for (int i = 0; i < ENQ_W; i++) begin
      if (i >= base && i < base + wr_n) begin
        mem_we[PW'(int'(tail_q) + i - base)] = 1'b1;
        mem_d[PW'(int'(tail_q) + i - base)]  = lane[i];
        if (is_br(lane[i])) br_in = br_in + 1;
      end
    end

    br_out = 0;
    rd     = '0;
    for (int j = 0; j < DEQ_W; j++) begin
      if (!byp && j < take) begin
        rd = mem_q[PW'(int'(head_q) + j)];
        if (is_br(rd)) br_out = br_out + 1;
      end
    end

    head_d = byp ? head_q : head_q + PW'(take);
    tail_d = tail_q + PW'(wr_n);
    occ_d  = occ_q + OW'(wr_n) - OW'(byp ? 0 : take);
    br_d   = br_q + OW'(br_in) - OW'(br_out);

    if (flush) begin
      head_d = '0;
      tail_d = '0;
      occ_d  = '0;
      br_d   = '0;
      mem_we = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
      br_q   <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
      br_q   <= br_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < DEPTH; k++) begin
      if (mem_we[k] && !reset) mem_q[k] <= mem_d[k];
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!reset && !flush)
      assert (deq_take <= deq_count)
      else $error("mop_queue: deq_take %0d exceeds deq_count %0d",
                  deq_take, deq_count);
  end
`endif

endmodule

// File: tb/tb_mop_queue.sv
// Randomised bench for mop_queue against a queue-based reference model.
// Honours MOP_QUEUE_BYPASS_EN when the bench is built with it.
module tb_mop_queue;
  import mop_pkg::*;

  localparam int DEPTH = 8;
  localparam int ENQ_W = 3;
  localparam int DEQ_W = 2;
  localparam int MW    = $bits(micro_op_t);
  localparam int NSTR  = 40;
`ifdef MOP_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                reset;
  logic                flush;
  logic [1:0]          enq_count;
  logic [ENQ_W*MW-1:0] enq_mops;
  logic                enq_ready;
  logic [1:0]          deq_count;
  logic [DEQ_W*MW-1:0] deq_mops;
  logic [1:0]          deq_take;
  logic [3:0]          occupancy;
  logic [3:0]          br_count;

  always #5 clk = ~clk;

  mop_queue #(.DEPTH(DEPTH), .ENQ_W(ENQ_W), .DEQ_W(DEQ_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .enq_count (enq_count),
    .enq_mops  (enq_mops),
    .enq_ready (enq_ready),
    .deq_count (deq_count),
    .deq_mops  (deq_mops),
    .deq_take  (deq_take),
    .occupancy (occupancy),
    .br_count  (br_count)
  );

  micro_op_t mq[$];
  int        out_log[$];
  int        acc_n;
  bit        chk_en;
  int        vectors;
  int        miscompares;

  function automatic micro_op_t mk(mop_op_e op, int seq);
    micro_op_t m;
    m        = '0;
    m.opcode = op;
    m.dst    = 4'(seq);
    m.src1   = 4'(seq + 3);
    m.src2   = 4'(seq + 7);
    m.disp   = 16'(seq);
    return m;
  endfunction

  function automatic micro_op_t lane_in(int i);
    micro_op_t m;
    m = enq_mops[i*MW +: MW];
    return m;
  endfunction

  function automatic micro_op_t lane_out(int j);
    micro_op_t m;
    m = deq_mops[j*MW +: MW];
    return m;
  endfunction

  function automatic int min2(int a, int b);
    return (a < b) ? a : b;
  endfunction

  function automatic bit is_jump(micro_op_t m);
    return (m.opcode > M_JMIN) && (m.opcode < M_JMAX);
  endfunction

  function automatic bit m_ready();
    return (DEPTH - mq.size()) >= ENQ_W;
  endfunction

  function automatic bit m_byp();
    return BYP && (mq.size() == 0) && !flush;
  endfunction

  function automatic int m_dc();
    if (m_byp()) return m_ready() ? min2(int'(enq_count), DEQ_W) : 0;
    return min2(mq.size(), DEQ_W);
  endfunction

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: state advances on each rising edge
  always @(posedge clk) begin : mdl
    int n, dc, tk;
    bit rdy, bp;
    micro_op_t m;
    acc_n = 0;
    if (reset || flush) begin
      mq.delete();
    end else begin
      n   = int'(enq_count);
      rdy = m_ready();
      bp  = m_byp();
      dc  = m_dc();
      tk  = min2(int'(deq_take), dc);
      if (bp) begin
        for (int j = 0; j < tk; j++) begin
          m = lane_in(j);
          out_log.push_back(int'(m.disp));
        end
        if (rdy) for (int i = tk; i < n; i++) mq.push_back(lane_in(i));
      end else begin
        for (int j = 0; j < tk; j++) begin
          m = mq.pop_front();
          out_log.push_back(int'(m.disp));
        end
        if (rdy) for (int i = 0; i < n; i++) mq.push_back(lane_in(i));
      end
      if (rdy) acc_n = n;
    end
  end

  always @(negedge clk) begin : cmp
    int br, dc;
    logic [DEQ_W*MW-1:0] exp_m;
    if (chk_en) begin
      br = 0;
      foreach (mq[k]) if (is_jump(mq[k])) br++;
      dc    = m_dc();
      exp_m = '0;
      for (int j = 0; j < dc; j++)
        exp_m[j*MW +: MW] = m_byp() ? lane_in(j) : mq[j];
      check("occupancy", occupancy, mq.size());
      check("br_count", br_count, br);
      check("enq_ready", enq_ready, m_ready());
      check("deq_count", deq_count, dc);
      check("deq_mops", deq_mops, exp_m);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    flush     = 1'b0;
    enq_count = '0;
    enq_mops  = '0;
    deq_take  = '0;
  endtask

  task automatic set_enq(input int n, input micro_op_t a,
                         input micro_op_t b, input micro_op_t c);
    enq_mops           = '0;
    enq_mops[0 +: MW]  = a;
    enq_mops[MW +: MW] = b;
    enq_mops[2*MW +: MW] = c;
    enq_count          = 2'(n);
  endtask

  micro_op_t stream [NSTR];
  micro_op_t t;
  int        next_seq;
  int        n;

  initial begin
    vectors     = 0;
    miscompares = 0;
    chk_en      = 1'b0;
    reset       = 1'b1;
    idle_in();
    repeat (2) @(posedge clk);
    #1;
    reset  = 1'b0;
    chk_en = 1'b1;

    @(negedge clk);
    check("rst_occ", occupancy, 0);
    check("rst_br", br_count, 0);
    check("rst_dc", deq_count, 0);
    check("rst_rdy", enq_ready, 1);
    check("rst_mops", deq_mops, 0);

    tick();
    set_enq(3, mk(M_ADD, 0), mk(M_LD, 1), mk(M_JZ, 2));
    tick();
    idle_in();
    @(negedge clk);
    t = lane_out(0);
    check("s1_occ", occupancy, 3);
    check("s1_br", br_count, 1);
    check("s1_dc", deq_count, 2);
    check("s1_l0", t.opcode, M_ADD);
    t = lane_out(1);
    check("s1_l1", t.opcode, M_LD);

    tick();
    set_enq(3, mk(M_SUB, 3), mk(M_ST, 4), mk(M_MUL, 5));
    tick();
    idle_in();
    @(negedge clk);
    check("full_occ", occupancy, 6);
    check("full_rdy", enq_ready, 0);
    tick();
    set_enq(3, mk(M_JMP, 6), mk(M_JNZ, 7), mk(M_CALL, 8));
    tick();
    idle_in();
    @(negedge clk);
    check("ign_occ", occupancy, 6);
    check("ign_br", br_count, 1);
    tick();
    deq_take = 2'd2;
    tick();
    idle_in();
    @(negedge clk);
    t = lane_out(0);
    check("deq_occ", occupancy, 4);
    check("deq_rdy", enq_ready, 1);
    check("deq_l0", t.opcode, M_JZ);

    tick();
    flush = 1'b1;
    tick();
    idle_in();
    set_enq(3, mk(M_JMP, 10), mk(M_ADD, 11), mk(M_JNZ, 12));
    tick();
    set_enq(2, mk(M_SUB, 13), mk(M_LD, 14), mk(M_NOP, 0));
    tick();
    idle_in();
    @(negedge clk);
    check("pre_fl_occ", occupancy, 5);
    check("pre_fl_br", br_count, 2);
    tick();
    flush    = 1'b1;
    set_enq(3, mk(M_CALL, 15), mk(M_RET, 16), mk(M_JZ, 17));
    deq_take = 2'd2;
    tick();
    idle_in();
    @(negedge clk);
    check("fl_occ", occupancy, 0);
    check("fl_br", br_count, 0);
    check("fl_dc", deq_count, 0);
    check("fl_rdy", enq_ready, 1);

    tick();
    set_enq(3, mk(M_JMP, 20), mk(M_ADD, 21), mk(M_JNZ, 22));
    tick();
    set_enq(2, mk(M_SUB, 23), mk(M_LD, 24), mk(M_NOP, 0));
    tick();
    reset = 1'b1;
    set_enq(2, mk(M_ST, 25), mk(M_MUL, 26), mk(M_NOP, 0));
    tick();
    reset = 1'b0;
    idle_in();
    @(negedge clk);
    check("mr_occ", occupancy, 0);
    check("mr_br", br_count, 0);
    check("mr_dc", deq_count, 0);
    check("mr_rdy", enq_ready, 1);
    check("mr_mops", deq_mops, 0);
    tick();
    set_enq(1, mk(M_MUL, 77), mk(M_NOP, 0), mk(M_NOP, 0));
    tick();
    idle_in();
    @(negedge clk);
    t = dut.mem_q[0];
    check("mr_idx0", t.disp, 77);
    t = lane_out(0);
    check("mr_l0", t.disp, 77);

    tick();
    flush = 1'b1;
    tick();
    idle_in();
    set_enq(2, mk(M_SUB, 30), mk(M_JMP, 31), mk(M_NOP, 0));
    deq_take = BYP ? 2'd1 : 2'd0;
    @(negedge clk);
    check("byp_dc", deq_count, BYP ? 2 : 0);
    check("byp_l0", deq_mops[MW-1:0], BYP ? mk(M_SUB, 30) : '0);
    tick();
    idle_in();
    @(negedge clk);
    check("byp_occ", occupancy, BYP ? 1 : 2);
    check("byp_br", br_count, 1);

    tick();
    flush = 1'b1;
    tick();
    idle_in();
    out_log.delete();
    for (int s = 0; s < NSTR; s++)
      stream[s] = mk(mop_op_e'($urandom_range(0, 13)), s);
    next_seq = 0;
    for (int c = 0; c < 600 && out_log.size() < NSTR; c++) begin
      n = (next_seq < NSTR) ? min2(int'($urandom_range(1, 3)), NSTR - next_seq) : 0;
      enq_mops = '0;
      for (int i = 0; i < n; i++) enq_mops[i*MW +: MW] = stream[next_seq + i];
      enq_count = 2'(n);
      deq_take  = 2'($urandom_range(0, m_dc()));
      tick();
      next_seq += acc_n;
    end
    idle_in();
    check("stream_len", out_log.size(), NSTR);
    foreach (out_log[k]) check("stream_order", out_log[k], k);

    tick();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mop_queue.md
# mop_queue

Parametrised micro-op buffer between the x86 decoder and the register-read stage. Each cycle it accepts up to ENQ_W `micro_op_t` entries from the decoder and presents up to DEQ_W of them in program order. It supports a single-cycle flush on branch redirect and keeps a live count of queued jump micro-ops. It replaces the single-entry decoder-to-RR latch.

## Interface
Parameters:
- DEPTH, 16: entry count; power of two, ≥ 2*ENQ_W.
- ENQ_W, 3: maximum micro-ops enqueued per cycle, 1..4.
- DEQ_W, 2: maximum micro-ops dequeued per cycle, 1..DEPTH.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  discard all queued entries.
- enq_count  in  $clog2(ENQ_W+1)  number of valid lanes; lanes 0..enq_count-1 are valid.
- enq_mops  in  ENQ_W*$bits(micro_op_t)  lane i occupies slice i; lane 0 is oldest.
- enq_ready  out  1  queue can accept a full ENQ_W group this cycle.
- deq_count  out  $clog2(DEQ_W+1)  number of valid output lanes.
- deq_mops  out  DEQ_W*$bits(micro_op_t)  lane 0 is the oldest entry.
- deq_take  in  $clog2(DEQ_W+1)  number of lanes consumed this cycle; must be ≤ deq_count.
- occupancy  out  $clog2(DEPTH+1)  entries currently stored.
- br_count  out  $clog2(DEPTH+1)  stored entries whose opcode lies strictly between M_JMIN and M_JMAX.

## Operation
- Storage is a circular array of DEPTH `micro_op_t` entries with head and tail pointers. Pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH.
- enq_ready = (DEPTH − occupancy ≥ ENQ_W).
  - Computed from registered occupancy only; same-cycle dequeues do not count.
  - There is no combinational path from deq_take to enq_ready.
- Enqueue fires when enq_ready && enq_count>0 && !flush.
  - Lanes 0..enq_count-1 are written at tail..tail+enq_count-1 (mod DEPTH).
  - tail advances by enq_count.
  - When enq_ready=0, enq lanes are ignored. The decoder must hold them.
- Dequeue:
  - deq_count = min(occupancy, DEQ_W).
  - Output lane j = entry[head+j], for j < deq_count.
  - Output lanes j ≥ deq_count drive all-zeros.
  - head advances by deq_take. If deq_take > deq_count, the simulation assertion fires and the value is treated as deq_count.
- occupancy_next = occupancy + enq_accepted − deq_take. A simultaneous enqueue and dequeue is legal at any occupancy, including full and empty.
- br_count_next = br_count + (branches among accepted enq lanes) − (branches among taken deq lanes). It equals the number of stored entries with M_JMIN < opcode < M_JMAX.
- Priority order: reset > flush > enqueue/dequeue.
  - flush sets head=tail=0, occupancy=0 and br_count=0 on the next edge.
  - Same-cycle enqueue and deq_take are discarded.
- Reset values:
  - occupancy=0, br_count=0, deq_count=0, deq_mops=0, enq_ready=1.
  - Entry contents are not reset.
- Reset mid-operation discards all entries exactly as flush does.

## Timing
- Latency without bypass: an entry enqueued at edge N is visible on deq_mops in cycle N+1 at the earliest.
- Throughput: ENQ_W in and DEQ_W out every cycle, with no bubbles at wrap-around.
- deq_count, deq_mops, occupancy, br_count and enq_ready are driven from registers, or from a register-indexed array read. There is no input-to-output combinational path, except under bypass (see Configuration).

## Configuration
- MOP_QUEUE_BYPASS_EN defined, and occupancy==0 and !flush:
  - Output lanes are driven combinationally from enq lanes: deq_count = min(enq_count, DEQ_W) when enq_ready.
  - deq_take consumes from those lanes. Only the remaining enq_count − deq_take lanes are written.
  - tail and head advance consistently; br_count counts only the written lanes.
  - This creates a combinational path enq → deq.
- MOP_QUEUE_BYPASS_EN undefined: no bypass; the 1-cycle minimum latency always applies.

## Test plan
All scenarios use DEPTH=8, ENQ_W=3, DEQ_W=2.
- Reset, then enq_count=3 {m_add, m_ld, m_jz}, deq_take=0 → next cycle: occupancy=3, br_count=1, deq_count=2, lanes = m_add, m_ld.
- Enqueue 3 per cycle with no dequeue → after the 2nd edge occupancy=6 and enq_ready=0; the third group is ignored. Then deq_take=2 → occupancy=4, enq_ready=1.
- Stream 40 ops, each with a sequence number in disp, enqueuing 1–3 per cycle and taking 0–2 per cycle at random → output order is 0..39 with no loss across repeated wrap-around; br_count matches the reference model every cycle.
- Occupancy=5 (2 jumps), with flush=1 in the same cycle as enq_count=3 and deq_take=2 → next cycle: occupancy=0, br_count=0, deq_count=0, enq_ready=1.
- Occupancy=5, reset asserted for one cycle alongside enq_count=2 → next cycle: all outputs at their reset values; a subsequent enqueue lands at index 0.
- Empty queue, enq_count=2 {m_sub, m_jmp}, deq_take=1:
  - With MOP_QUEUE_BYPASS_EN: same-cycle deq_count=2, lane0=m_sub; next cycle occupancy=1, br_count=1.
  - Without it: same-cycle deq_count=0 (deq_take driven 0); next cycle occupancy=2.
